// File: rtl/pixel_row_loader_if.sv
// Pixel stream and row-register write bus for the image loader.
// master: loader side (takes pixels, drives row word/address/strobes).
// slave : environment side (pixel source, row register array).
interface pixel_row_loader_if #(
  parameter int NrOfBits = 28,
  parameter int AddrBits = 5
);
  logic                PixelIn;
  logic                PixelValid;
  logic                PixelReady;
  logic [NrOfBits-1:0] WordOut;
  logic [AddrBits-1:0] WordAddr;
  logic                WordWrite;
  logic                ClearRegs;

  modport master (
    input  PixelIn, PixelValid,
    output PixelReady, WordOut, WordAddr, WordWrite, ClearRegs
  );

  modport slave (
    output PixelIn, PixelValid,
    input  PixelReady, WordOut, WordAddr, WordWrite, ClearRegs
  );
endinterface

// File: rtl/pixel_row_loader.sv
// Packs a serial 1-bit pixel stream into NrOfBits-wide row words and writes
// NrOfRows rows (with a clear pulse first) into the image register array.
// Ports: Clock, Reset (async, active-high), Start, Abort, Busy, Done, and
// bus (pixel valid/ready stream in, WordOut/WordAddr/WordWrite/ClearRegs out).
// Every output is a register; there is no input-to-output combinational path.
module pixel_row_loader #(
  parameter int NrOfBits = 28,
  parameter int NrOfRows = 28,
  parameter int AddrBits = 5
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    Abort,
  pixel_row_loader_if.master      bus,
  output logic                    Busy,
  output logic                    Done
);

  localparam int CntBits = (NrOfBits > 1) ? $clog2(NrOfBits) : 1;
  localparam logic [CntBits-1:0]  LastPix = CntBits'(NrOfBits - 1);
  localparam logic [AddrBits-1:0] LastRow = AddrBits'(NrOfRows - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    WRITE,
    DONE
  } state_t;

  state_t             state;
  logic [CntBits-1:0] pix_cnt;

  // Outputs are registered alongside the state, so each one is set on the
  // edge that enters the state it belongs to.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      pix_cnt        <= '0;
      bus.WordOut    <= '0;
      bus.WordAddr   <= '0;
      bus.WordWrite  <= 1'b0;
      bus.ClearRegs  <= 1'b0;
      bus.PixelReady <= 1'b0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
    end else begin
      // One-cycle strobes default low.
      bus.WordWrite <= 1'b0;
      bus.ClearRegs <= 1'b0;
      Done          <= 1'b0;

      if (Abort) begin
        // Abort beats Start and everything else; rows already written stay.
        state          <= IDLE;
        pix_cnt        <= '0;
        bus.WordOut    <= '0;
        bus.WordAddr   <= '0;
        bus.PixelReady <= 1'b0;
        Busy           <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (Start) begin
              state         <= CLEAR;
              bus.ClearRegs <= 1'b1;
              Busy          <= 1'b1;
            end
          end

          CLEAR: begin
            pix_cnt        <= '0;
            bus.WordOut    <= '0;
            bus.WordAddr   <= '0;
            state          <= SHIFT;
            bus.PixelReady <= 1'b1;
          end

          SHIFT: begin
            if (bus.PixelValid) begin
              // First pixel of a row ends up in the MSB (leftmost column).
              bus.WordOut <= {bus.WordOut[NrOfBits-2:0], bus.PixelIn};
              if (pix_cnt == LastPix) begin
                pix_cnt        <= '0;
                state          <= WRITE;
                bus.PixelReady <= 1'b0;
                bus.WordWrite  <= 1'b1;
              end else begin
                pix_cnt <= pix_cnt + CntBits'(1);
              end
            end
          end

          WRITE: begin
            if (bus.WordAddr == LastRow) begin
              // Address holds on the last row; it never wraps within a frame.
              state <= DONE;
              Done  <= 1'b1;
            end else begin
              bus.WordAddr   <= bus.WordAddr + AddrBits'(1);
              state          <= SHIFT;
              bus.PixelReady <= 1'b1;
            end
          end

          DONE: begin
            state <= IDLE;
            Busy  <= 1'b0;
          end

          default: begin
            state          <= IDLE;
            bus.PixelReady <= 1'b0;
            Busy           <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_row_loader.sv
module tb_pixel_row_loader;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  // Small instance: 4 pixels per row, 2 rows.
  logic s_start, s_abort, s_busy, s_done;
  pixel_row_loader_if #(.NrOfBits(4), .AddrBits(1)) s_bus ();
  pixel_row_loader #(.NrOfBits(4), .NrOfRows(2), .AddrBits(1)) dut_s (
    .Clock (Clock),
    .Reset (Reset),
    .Start (s_start),
    .Abort (s_abort),
    .bus   (s_bus),
    .Busy  (s_busy),
    .Done  (s_done)
  );

  // Default-size instance: 28 x 28.
  logic d_start, d_abort, d_busy, d_done;
  pixel_row_loader_if #(.NrOfBits(28), .AddrBits(5)) d_bus ();
  pixel_row_loader #(.NrOfBits(28), .NrOfRows(28), .AddrBits(5)) dut_d (
    .Clock (Clock),
    .Reset (Reset),
    .Start (d_start),
    .Abort (d_abort),
    .bus   (d_bus),
    .Busy  (d_busy),
    .Done  (d_done)
  );

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // {ready, clr, wr, busy, done, addr, word}
  function automatic logic [9:0] obs_s();
    return {s_bus.PixelReady, s_bus.ClearRegs, s_bus.WordWrite, s_busy, s_done,
            s_bus.WordAddr, s_bus.WordOut};
  endfunction

  typedef struct {
    logic       start, abort, valid, pin;
    logic [9:0] exp;
  } vec_t;

  function automatic vec_t mk(logic start, logic abort, logic valid, logic pin,
                              logic rdy, logic clr, logic wr, logic busy, logic done,
                              logic addr, logic [3:0] word);
    vec_t v;
    v.start = start; v.abort = abort; v.valid = valid; v.pin = pin;
    v.exp   = {rdy, clr, wr, busy, done, addr, word};
    return v;
  endfunction

  logic [3:0] wr_word [2];
  logic       wr_addr [2];

  // Streams pixels 1011 0110 into the small instance from its Start cycle.
  // toggle: PixelValid only on even cycles. poke: extra Start during SHIFT.
  task automatic run_small(input bit toggle, input bit poke,
                           output int nwr, output int nclr, output int done_cyc);
    logic [7:0] pat;
    int idx;
    bit acc;
    pat = 8'b1011_0110;
    idx = 0;
    nwr = 0; nclr = 0; done_cyc = -1;
    for (int k = 0; k < 60 && done_cyc < 0; k++) begin
      if (s_bus.ClearRegs) nclr++;
      if (s_bus.WordWrite) begin
        if (nwr < 2) begin
          wr_word[nwr] = s_bus.WordOut;
          wr_addr[nwr] = s_bus.WordAddr;
        end
        nwr++;
      end
      if (s_done) done_cyc = k;
      s_start = (k == 0) || (poke && k == 4);
      s_bus.PixelValid = (toggle ? (k % 2 == 0) : 1'b1) && (idx < 8);
      s_bus.PixelIn    = (idx < 8) ? pat[7-idx] : 1'b0;
      acc = s_bus.PixelValid && s_bus.PixelReady;
      @(posedge Clock); #1;
      if (acc) idx++;
    end
    s_start = 1'b0;
    s_bus.PixelValid = 1'b0;
  endtask

  vec_t vecs [16];
  int nwr, nclr, done_cyc;

  initial begin
    Reset = 1'b1;
    s_start = 0; s_abort = 0; s_bus.PixelValid = 0; s_bus.PixelIn = 0;
    d_start = 0; d_abort = 0; d_bus.PixelValid = 0; d_bus.PixelIn = 0;

    vecs[0]  = mk(1,0,0,0, 0,0,0,0,0, 0, 4'h0);
    vecs[1]  = mk(0,0,1,1, 0,1,0,1,0, 0, 4'h0);
    vecs[2]  = mk(0,0,1,1, 1,0,0,1,0, 0, 4'h0);
    vecs[3]  = mk(0,0,1,0, 1,0,0,1,0, 0, 4'h1);
    vecs[4]  = mk(0,0,1,1, 1,0,0,1,0, 0, 4'h2);
    vecs[5]  = mk(0,0,1,1, 1,0,0,1,0, 0, 4'h5);
    vecs[6]  = mk(0,0,1,0, 0,0,1,1,0, 0, 4'hB);
    vecs[7]  = mk(0,0,1,0, 1,0,0,1,0, 1, 4'hB);
    vecs[8]  = mk(0,0,1,1, 1,0,0,1,0, 1, 4'h6);
    vecs[9]  = mk(0,0,1,1, 1,0,0,1,0, 1, 4'hD);
    vecs[10] = mk(0,0,1,0, 1,0,0,1,0, 1, 4'hB);
    vecs[11] = mk(0,0,0,0, 0,0,1,1,0, 1, 4'h6);
    vecs[12] = mk(0,0,0,0, 0,0,0,1,1, 1, 4'h6);
    vecs[13] = mk(1,1,0,0, 0,0,0,0,0, 1, 4'h6);
    vecs[14] = mk(0,0,0,0, 0,0,0,0,0, 0, 4'h0);
    vecs[15] = mk(0,0,0,0, 0,0,0,0,0, 0, 4'h0);

    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    chk("reset_small", obs_s(), 10'h0);
    chk("reset_default",
        {d_bus.PixelReady, d_bus.ClearRegs, d_bus.WordWrite, d_busy, d_done,
         d_bus.WordAddr, d_bus.WordOut}, 0);

    // Held-valid frame, then Start+Abort together in IDLE.
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("vec%0d", i), obs_s(), vecs[i].exp);
      s_start = vecs[i].start; s_abort = vecs[i].abort;
      s_bus.PixelValid = vecs[i].valid; s_bus.PixelIn = vecs[i].pin;
      @(posedge Clock); #1;
    end
    s_start = 0; s_abort = 0; s_bus.PixelValid = 0;

    // Toggling valid plus a re-pulsed Start during SHIFT.
    run_small(1'b1, 1'b1, nwr, nclr, done_cyc);
    chk("toggle_nwr", nwr, 2);
    chk("toggle_word0", {wr_addr[0], wr_word[0]}, {1'b0, 4'b1011});
    chk("toggle_word1", {wr_addr[1], wr_word[1]}, {1'b1, 4'b0110});
    chk("toggle_clears", nclr, 1);
    chk("toggle_done_cycle", done_cyc, 18);
    @(posedge Clock); #1;

    // Abort after two pixels of row 1.
    nwr = 0;
    for (int k = 0; k < 10; k++) begin
      if (s_bus.WordWrite) nwr++;
      s_start = (k == 0);
      s_abort = (k == 9);
      s_bus.PixelValid = (k < 9);
      s_bus.PixelIn = 1'b1;
      @(posedge Clock); #1;
    end
    s_abort = 0;
    chk("abort_writes", nwr, 1);
    chk("abort_state", obs_s(), 10'h0);

    // Fresh frame after abort, held valid.
    run_small(1'b0, 1'b0, nwr, nclr, done_cyc);
    chk("reload_nwr", nwr, 2);
    chk("reload_word0", {wr_addr[0], wr_word[0]}, {1'b0, 4'b1011});
    chk("reload_word1", {wr_addr[1], wr_word[1]}, {1'b1, 4'b0110});
    chk("reload_done_cycle", done_cyc, 12);
    @(posedge Clock); #1;

    // Async reset in the middle of the row-1 WRITE cycle.
    for (int k = 0; k < 11; k++) begin
      s_start = (k == 0);
      s_bus.PixelValid = 1'b1;
      s_bus.PixelIn = 1'b1;
      @(posedge Clock); #1;
    end
    s_bus.PixelValid = 0;
    chk("pre_reset_write", {s_bus.WordWrite, s_bus.WordAddr, s_bus.WordOut}, {1'b1, 1'b1, 4'hF});
    #2 Reset = 1'b1;
    #1 chk("async_reset", obs_s(), 10'h0);
    #2 Reset = 1'b0;
    @(posedge Clock); #1;
    chk("after_reset_idle", obs_s(), 10'h0);

    // Default size, all-ones image.
    nwr = 0; done_cyc = -1;
    for (int k = 0; k < 900 && done_cyc < 0; k++) begin
      if (d_bus.WordWrite) begin
        chk($sformatf("dflt_row%0d", nwr), {d_bus.WordAddr, d_bus.WordOut},
            {5'(nwr), 28'hFFFFFFF});
        nwr++;
      end
      if (d_done) done_cyc = k + 1;
      d_start = (k == 0);
      d_bus.PixelValid = 1'b1;
      d_bus.PixelIn = 1'b1;
      @(posedge Clock); #1;
    end
    d_start = 0; d_bus.PixelValid = 0;
    chk("dflt_nwr", nwr, 28);
    chk("dflt_done_cycle", done_cyc, 815);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
